pwm_generator: RTL and testbench
================================

Name: pwm_generator

Overview:
- Downstream stage of the motor PID controller.
- Consumes the PID's pwm_ratio, pwm_update, pwm_direction and pwm_enable, and produces the physical PWM and direction pins for the motor driver.
- Ratio and direction changes are applied only on PWM period boundaries. A reversal inserts a dead-time of zero drive before the direction pin flips.
- Each applied update is acknowledged to the PID with a one-cycle pwm_done pulse.

Parameters:
- CLK_DIV, 4, clock cycles per PWM count (prescaler). Legal range 1..65535. PWM period = 256*CLK_DIV clocks.
- DEAD_PERIODS, 2, number of full PWM periods of zero drive inserted on a direction reversal. Legal range 1..15.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pwm_enable  in  1  drive enable from the motor control register
- pwm_update  in  1  level or pulse: sample pwm_ratio/pwm_direction this cycle
- pwm_ratio  in  8  requested high time, out of 256 counts
- pwm_direction  in  1  requested motor direction
- pwm_done  out  1  one-cycle pulse: requested ratio now active
- pwm_out  out  1  PWM drive to motor driver
- dir_out  out  1  direction drive to motor driver
- active_ratio  out  8  ratio currently being driven (debug)
- state_dbg  out  2  FSM state (debug)

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: pwm_out=0, dir_out=0, pwm_done=0, active_ratio=0, state_dbg=OFF. Internal prescaler, count, dead counter, pending regs and pending_valid are all cleared.
- Reset mid-operation is applied at the next edge; no dead-time is honoured.
- Prescaler:
  - presc counts 0..CLK_DIV-1 in RUN and DEAD states only.
  - tick=1 when presc==CLK_DIV-1.
  - On tick, count (8b) increments and wraps 255->0.
  - Boundary = tick && count==255.
- pwm_out is registered: pwm_out <= (state==RUN) && (count < active_ratio).
  - Ratio 0 gives a constant low output.
  - Ratio 255 gives 255/256 duty; 100% duty is not required.
- Pending capture: in any cycle with pwm_update=1 and state!=OFF:
  - pending_ratio <= pwm_ratio, pending_dir <= pwm_direction, pending_valid <= 1.
  - A later sample overwrites an earlier unapplied one; only the latest sample is applied.
- FSM states: OFF=0, RUN=1, DEAD=2.
  - OFF: outputs low, presc/count held at 0, pending cleared, active_ratio=0, dir_out holds its last value. pwm_enable=1 -> RUN next cycle, with count starting at 0.
  - RUN: on a boundary with pending_valid:
    - If pending_dir==dir_out: active_ratio <= pending_ratio, pwm_done pulses high for the next cycle, pending_valid cleared.
    - Otherwise: active_ratio <= 0, dead_cnt <= DEAD_PERIODS, state -> DEAD. pending_valid is kept.
  - DEAD: pwm_out=0. Each boundary decrements dead_cnt. On the boundary where dead_cnt==1: dir_out <= pending_dir, active_ratio <= pending_ratio, pwm_done pulses, pending_valid cleared, state -> RUN.
  - A new sample arriving during DEAD replaces the pending values:
    - If its direction equals dir_out, the dead time still completes before the update is applied.
- Any state with pwm_enable=0 goes to OFF next cycle and pwm_out goes low in that same next cycle. This overrides any boundary event in that cycle; no pwm_done is issued.
- Simultaneous pwm_update and boundary: the boundary applies the pending value that was registered before this cycle. The new sample becomes pending for the following boundary.
- pwm_done latency: asserted exactly 1 clock after the applying boundary. It never asserts twice for one sample.

Decomposition:
- Shared package pwm_pkg holds:
  - state encodings OFF/RUN/DEAD
  - PWM_COUNT_W=8 and PWM_MAX=255
  - DEAD_CNT_W=4
- One natural sub-module: pwm_prescaler (CLK_DIV counter; clear input; tick output).

Test Plan:
1. CLK_DIV=2. Reset, then enable; pwm_update pulse with ratio=64, dir=0 -> pwm_done exactly once, 1 clock after the first boundary (clock 512 after enable). Then pwm_out is high for 128 clocks of each 512-clock period.
2. Running at ratio 64, apply ratio=200 mid-period -> pwm_out waveform is unchanged until the boundary. The next period is high for 400 clocks; active_ratio=200.
3. Running dir=0 ratio=100, then update to dir=1 ratio=150 with DEAD_PERIODS=2 -> pwm_out low for 2 full periods and dir_out flips at the second boundary. Then 300 high clocks per period, with a single pwm_done.
4. Hold pwm_update high with ratio=0, then ratio=255 -> ratio 0 gives constant low output; ratio 255 gives 510 high and 2 low clocks per period. pwm_done pulses once per period while pwm_update is held.
5. Drop pwm_enable during DEAD -> OFF next cycle: pwm_out=0, active_ratio=0, dir_out unchanged, no pwm_done. Re-enable -> count restarts from 0.
6. Assert reset mid-period at ratio 128 -> all outputs take their reset values on the next edge. A subsequent enable plus update behaves as in test 1.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the motor PWM stage: FSM encoding and counter widths.
package pwm_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } pwm_state_e;

    localparam int                    PWM_COUNT_W = 8;
    localparam logic [PWM_COUNT_W-1:0] PWM_MAX    = 8'd255;
    localparam int                    DEAD_CNT_W  = 4;

endpackage

// File: rtl/pwm_prescaler.sv
// Divides the system clock by CLK_DIV; tick marks the last clock of each PWM count.
module pwm_prescaler #(
    parameter int CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int                PRESC_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;

    always_comb begin
        presc_d = presc_q + PRESC_W'(1);
        if (clear || (presc_q == PRESC_LAST)) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // Gated so that CLK_DIV=1 cannot tick while the generator is off.
    assign tick = !clear && (presc_q == PRESC_LAST);

endmodule

// File: rtl/pwm_generator.sv
// PWM output stage for the motor PID: period-aligned ratio/direction updates with
// dead-time on reversal and a one-cycle pwm_done acknowledge per applied update.
module pwm_generator
    import pwm_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int DEAD_PERIODS = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   pwm_enable,
    input  logic                   pwm_update,
    input  logic [PWM_COUNT_W-1:0] pwm_ratio,
    input  logic                   pwm_direction,
    output logic                   pwm_done,
    output logic                   pwm_out,
    output logic                   dir_out,
    output logic [PWM_COUNT_W-1:0] active_ratio,
    output logic [1:0]             state_dbg
);

    pwm_state_e             state_q, state_d;
    logic [PWM_COUNT_W-1:0] count_q, count_d;
    logic [DEAD_CNT_W-1:0]  dead_cnt_q, dead_cnt_d;
    logic [PWM_COUNT_W-1:0] active_ratio_q, active_ratio_d;
    logic [PWM_COUNT_W-1:0] pend_ratio_q, pend_ratio_d;
    logic                   pend_dir_q, pend_dir_d;
    logic                   pend_valid_q, pend_valid_d;
    logic                   pwm_out_q, pwm_out_d;
    logic                   dir_out_q, dir_out_d;
    logic                   pwm_done_q, pwm_done_d;
    logic                   tick;
    logic                   boundary;

    pwm_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
        .clock (clock),
        .reset (reset),
        .clear (state_q == OFF),
        .tick  (tick)
    );

    assign boundary = tick && (count_q == PWM_MAX);

    always_comb begin
        state_d        = state_q;
        count_d        = tick ? count_q + 8'd1 : count_q;
        dead_cnt_d     = dead_cnt_q;
        active_ratio_d = active_ratio_q;
        pend_ratio_d   = pend_ratio_q;
        pend_dir_d     = pend_dir_q;
        pend_valid_d   = pend_valid_q;
        dir_out_d      = dir_out_q;
        pwm_done_d     = 1'b0;
        pwm_out_d      = (state_q == RUN) && (count_q < active_ratio_q);

        case (state_q)
            OFF: begin
                count_d        = '0;
                active_ratio_d = '0;
                pend_ratio_d   = '0;
                pend_dir_d     = 1'b0;
                pend_valid_d   = 1'b0;
                if (pwm_enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (boundary && pend_valid_q) begin
                    if (pend_dir_q == dir_out_q) begin
                        active_ratio_d = pend_ratio_q;
                        pwm_done_d     = 1'b1;
                        pend_valid_d   = 1'b0;
                    end else begin
                        active_ratio_d = '0;
                        dead_cnt_d     = DEAD_CNT_W'(DEAD_PERIODS);
                        state_d        = DEAD;
                    end
                end
            end
            DEAD: begin
                if (boundary) begin
                    if (dead_cnt_q == DEAD_CNT_W'(1)) begin
                        dir_out_d      = pend_dir_q;
                        active_ratio_d = pend_ratio_q;
                        pwm_done_d     = 1'b1;
                        pend_valid_d   = 1'b0;
                        state_d        = RUN;
                    end else begin
                        dead_cnt_d = dead_cnt_q - DEAD_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = OFF;
            end
        endcase

        // Captured after the boundary logic so a coincident sample waits for the next boundary.
        if (pwm_update && (state_q != OFF)) begin
            pend_ratio_d = pwm_ratio;
            pend_dir_d   = pwm_direction;
            pend_valid_d = 1'b1;
        end

        if (!pwm_enable) begin
            state_d        = OFF;
            pwm_out_d      = 1'b0;
            active_ratio_d = '0;
            pend_valid_d   = 1'b0;
            pwm_done_d     = 1'b0;
            dead_cnt_d     = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= OFF;
            count_q        <= '0;
            dead_cnt_q     <= '0;
            active_ratio_q <= '0;
            pend_ratio_q   <= '0;
            pend_dir_q     <= 1'b0;
            pend_valid_q   <= 1'b0;
            pwm_out_q      <= 1'b0;
            dir_out_q      <= 1'b0;
            pwm_done_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            dead_cnt_q     <= dead_cnt_d;
            active_ratio_q <= active_ratio_d;
            pend_ratio_q   <= pend_ratio_d;
            pend_dir_q     <= pend_dir_d;
            pend_valid_q   <= pend_valid_d;
            pwm_out_q      <= pwm_out_d;
            dir_out_q      <= dir_out_d;
            pwm_done_q     <= pwm_done_d;
        end
    end

    assign pwm_done     = pwm_done_q;
    assign pwm_out      = pwm_out_q;
    assign dir_out      = dir_out_q;
    assign active_ratio = active_ratio_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_pwm_generator.sv
// Bench for pwm_generator: a time-based reference model (position within the PWM
// period derived from clocks since enable) is compared against the DUT every cycle.
module tb_pwm_generator;

    localparam int CLK_DIV      = 2;
    localparam int DEAD_PERIODS = 2;
    localparam int P            = 256 * CLK_DIV;

    logic       clock = 1'b0;
    logic       reset;
    logic       pwm_enable;
    logic       pwm_update;
    logic [7:0] pwm_ratio;
    logic       pwm_direction;
    logic       pwm_done;
    logic       pwm_out;
    logic       dir_out;
    logic [7:0] active_ratio;
    logic [1:0] state_dbg;

    always #5 clock = ~clock;

    pwm_generator #(.CLK_DIV(CLK_DIV), .DEAD_PERIODS(DEAD_PERIODS)) dut (
        .clock         (clock),
        .reset         (reset),
        .pwm_enable    (pwm_enable),
        .pwm_update    (pwm_update),
        .pwm_ratio     (pwm_ratio),
        .pwm_direction (pwm_direction),
        .pwm_done      (pwm_done),
        .pwm_out       (pwm_out),
        .dir_out       (dir_out),
        .active_ratio  (active_ratio),
        .state_dbg     (state_dbg)
    );

    // Reference model: m_mode 0=off, 1=run, 2=dead; m_t = clocks processed since enable.
    int         m_mode = 0;
    int         m_t = 0;
    int         m_dead_left = 0;
    logic       m_pwm = 1'b0, m_dir = 1'b0, m_done = 1'b0;
    logic       m_pdir = 1'b0, m_pvalid = 1'b0;
    logic [7:0] m_active = 8'd0, m_pratio = 8'd0;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [12:0] dut_vec();
        return {pwm_out, dir_out, pwm_done, active_ratio, state_dbg};
    endfunction

    function automatic logic [12:0] model_vec();
        return {m_pwm, m_dir, m_done, m_active, 2'(m_mode)};
    endfunction

    task automatic model_apply();
        m_active = m_pratio;
        m_done   = 1'b1;
        m_pvalid = 1'b0;
    endtask

    // Advance one clock, update the model from the inputs seen at that edge, settle.
    task automatic step();
        int pos;
        bit bnd;
        @(posedge clock);
        pos    = m_t % P;
        bnd    = (pos == P - 1);
        m_done = 1'b0;
        if (reset) begin
            m_mode = 0; m_t = 0; m_pwm = 0; m_dir = 0; m_active = 0;
            m_pvalid = 0; m_pratio = 0; m_pdir = 0; m_dead_left = 0;
        end else if (!pwm_enable) begin
            m_mode = 0; m_pwm = 0; m_active = 0; m_pvalid = 0;
        end else if (m_mode == 0) begin
            m_mode = 1; m_t = 0; m_pwm = 0;
        end else begin
            m_pwm = (m_mode == 1) && ((pos / CLK_DIV) < int'(m_active));
            if (bnd && m_mode == 2) begin
                if (m_dead_left == 1) begin
                    m_dir  = m_pdir;
                    model_apply();
                    m_mode = 1;
                end else begin
                    m_dead_left--;
                end
            end else if (bnd && m_pvalid) begin
                if (m_pdir == m_dir) begin
                    model_apply();
                end else begin
                    m_active    = 0;
                    m_dead_left = DEAD_PERIODS;
                    m_mode      = 2;
                end
            end
            if (pwm_update) begin
                m_pratio = pwm_ratio;
                m_pdir   = pwm_direction;
                m_pvalid = 1'b1;
            end
            m_t++;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; pwm_enable = 1'b1; pwm_update = 1'b1;
        pwm_ratio = 8'hAA; pwm_direction = 1'b1;
        step();
        step();
        n_checks++;
        if (dut_vec() !== 13'd0)
            $display("[TB] FAIL reset_values: got %h expected %h", dut_vec(), 13'd0);
        else n_pass++;
        reset = 1'b0; pwm_enable = 1'b0; pwm_update = 1'b0;
        step();
        n_checks++;
        if (dut_vec() !== model_vec())
            $display("[TB] FAIL reset_release: got %h expected %h", dut_vec(), model_vec());
        else n_pass++;
    endtask

    task automatic test_first_update(input string tag);
        int done_cnt = 0, done_at = -1, highs = 0;
        pwm_enable = 1'b1; pwm_update = 1'b0;
        step();
        n_checks++;
        if (state_dbg !== 2'd1)
            $display("[TB] FAIL %s_enter_run: got %0d expected 1", tag, state_dbg);
        else n_pass++;
        for (int k = 1; k <= 2 * P; k++) begin
            pwm_update = (k == 1); pwm_ratio = 8'd64; pwm_direction = 1'b0;
            step();
            n_checks++;
            if (dut_vec() !== model_vec())
                $display("[TB] FAIL %s_cycle %0d: got %h expected %h", tag, k, dut_vec(), model_vec());
            else n_pass++;
            if (pwm_done) begin done_cnt++; done_at = k; end
            if (k > P && pwm_out) highs++;
        end
        pwm_update = 1'b0;
        n_checks++;
        if (done_cnt != 1 || done_at != P)
            $display("[TB] FAIL %s_done: got count %0d at %0d expected 1 at %0d", tag, done_cnt, done_at, P);
        else n_pass++;
        n_checks++;
        if (highs != 64 * CLK_DIV)
            $display("[TB] FAIL %s_high_clocks: got %0d expected %0d", tag, highs, 64 * CLK_DIV);
        else n_pass++;
    endtask

    task automatic test_ratio_change();
        int off = $urandom_range(20, P - 20);
        int h0 = 0, h1 = 0;
        for (int k = 1; k <= 2 * P; k++) begin
            pwm_update = (k == off);
            pwm_ratio  = (k == off) ? 8'd200 : 8'($urandom);
            pwm_direction = 1'b0;
            step();
            n_checks++;
            if (dut_vec() !== model_vec())
                $display("[TB] FAIL ratio_change_cycle %0d: got %h expected %h", k, dut_vec(), model_vec());
            else n_pass++;
            if (pwm_out) begin
                if (k <= P) h0++; else h1++;
            end
        end
        pwm_update = 1'b0;
        n_checks++;
        if (h0 != 128 || h1 != 400)
            $display("[TB] FAIL ratio_change_highs: got %0d/%0d expected 128/400", h0, h1);
        else n_pass++;
        n_checks++;
        if (active_ratio !== 8'd200)
            $display("[TB] FAIL ratio_change_active: got %0d expected 200", active_ratio);
        else n_pass++;
    endtask

    task automatic test_reversal();
        int off0 = $urandom_range(1, P - 1);
        int off1 = $urandom_range(1, P - 1);
        int highs[5] = '{default: 0};
        int dones[5] = '{default: 0};
        int flip_at = -1;
        for (int p = 0; p < 5; p++) begin
            for (int k = 1; k <= P; k++) begin
                pwm_update    = (p == 0 && k == off0) || (p == 1 && k == off1);
                pwm_ratio     = pwm_update ? ((p == 0) ? 8'd100 : 8'd150) : 8'($urandom);
                pwm_direction = pwm_update ? (p == 1) : 1'($urandom);
                step();
                n_checks++;
                if (dut_vec() !== model_vec())
                    $display("[TB] FAIL reversal_cycle %0d.%0d: got %h expected %h", p, k, dut_vec(), model_vec());
                else n_pass++;
                if (pwm_out) highs[p]++;
                if (pwm_done) dones[p]++;
                if (dir_out && flip_at < 0) flip_at = p * P + k;
            end
        end
        pwm_update = 1'b0;
        n_checks++;
        if (highs[1] != 200 || highs[2] != 0 || highs[3] != 0 || highs[4] != 300)
            $display("[TB] FAIL reversal_highs: got %0d %0d %0d %0d expected 200 0 0 300",
                     highs[1], highs[2], highs[3], highs[4]);
        else n_pass++;
        n_checks++;
        if (dones[0] != 1 || dones[1] != 0 || dones[2] != 0 || dones[3] != 1 || dones[4] != 0)
            $display("[TB] FAIL reversal_done: got %0d %0d %0d %0d %0d expected 1 0 0 1 0",
                     dones[0], dones[1], dones[2], dones[3], dones[4]);
        else n_pass++;
        n_checks++;
        if (flip_at != 4 * P)
            $display("[TB] FAIL reversal_dir_flip: got %0d expected %0d", flip_at, 4 * P);
        else n_pass++;
    endtask

    task automatic test_hold_update();
        int exp_highs[6] = '{300, 0, 0, 510, 510, 510};
        int exp_dones[6] = '{1, 1, 1, 1, 1, 0};
        for (int p = 0; p < 6; p++) begin
            int highs = 0, dones = 0;
            for (int k = 1; k <= P; k++) begin
                pwm_update    = (p < 4);
                pwm_ratio     = (p < 2) ? 8'd0 : 8'd255;
                pwm_direction = 1'b1;
                step();
                n_checks++;
                if (dut_vec() !== model_vec())
                    $display("[TB] FAIL hold_cycle %0d.%0d: got %h expected %h", p, k, dut_vec(), model_vec());
                else n_pass++;
                if (pwm_out) highs++;
                if (pwm_done) dones++;
            end
            n_checks++;
            if (highs != exp_highs[p] || dones != exp_dones[p])
                $display("[TB] FAIL hold_period %0d: got %0d high %0d done expected %0d high %0d done",
                         p, highs, dones, exp_highs[p], exp_dones[p]);
            else n_pass++;
        end
        pwm_update = 1'b0;
    endtask

    task automatic test_disable_in_dead();
        int n_dead = $urandom_range(1, 2 * P - 2);
        int dones = 0, done_at = -1, highs = 0;
        for (int k = 1; k <= P + n_dead; k++) begin
            pwm_update = (k == 1); pwm_ratio = 8'd50; pwm_direction = 1'b0;
            step();
            n_checks++;
            if (dut_vec() !== model_vec())
                $display("[TB] FAIL dead_cycle %0d: got %h expected %h", k, dut_vec(), model_vec());
            else n_pass++;
        end
        pwm_update = 1'b0; pwm_enable = 1'b0;
        step();
        n_checks++;
        if ({state_dbg, pwm_out, active_ratio, dir_out, pwm_done} !== {2'd0, 1'b0, 8'd0, 1'b1, 1'b0})
            $display("[TB] FAIL disable_in_dead: got st=%0d pwm=%b act=%0d dir=%b done=%b",
                     state_dbg, pwm_out, active_ratio, dir_out, pwm_done);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            pwm_update = 1'($urandom);
            step();
            if (pwm_done) dones++;
        end
        n_checks++;
        if (dones != 0 || dut_vec() !== model_vec())
            $display("[TB] FAIL disabled_hold: got %h done %0d expected %h done 0", dut_vec(), dones, model_vec());
        else n_pass++;
        pwm_update = 1'b0; pwm_enable = 1'b1;
        step();
        for (int k = 1; k <= 2 * P; k++) begin
            pwm_update = (k == 1); pwm_ratio = 8'd32; pwm_direction = 1'b1;
            step();
            n_checks++;
            if (dut_vec() !== model_vec())
                $display("[TB] FAIL reenable_cycle %0d: got %h expected %h", k, dut_vec(), model_vec());
            else n_pass++;
            if (pwm_done) done_at = k;
            if (k > P && pwm_out) highs++;
        end
        pwm_update = 1'b0;
        n_checks++;
        if (done_at != P || highs != 64)
            $display("[TB] FAIL reenable_restart: got done at %0d highs %0d expected %0d and 64", done_at, highs, P);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int k = 1; k <= 6 * P; k++) begin
            pwm_update    = ($urandom_range(0, 199) == 0);
            pwm_ratio     = 8'($urandom);
            pwm_direction = 1'($urandom);
            pwm_enable    = ($urandom_range(0, 2999) != 0);
            step();
            n_checks++;
            if (dut_vec() !== model_vec())
                $display("[TB] FAIL random_cycle %0d: got %h expected %h", k, dut_vec(), model_vec());
            else n_pass++;
        end
        pwm_update = 1'b0; pwm_enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        int off = $urandom_range(10, P - 10);
        pwm_enable = 1'b0;
        step();
        pwm_enable = 1'b1;
        step();
        for (int k = 1; k <= P + off; k++) begin
            pwm_update = (k == 1); pwm_ratio = 8'd128; pwm_direction = m_dir;
            step();
            n_checks++;
            if (dut_vec() !== model_vec())
                $display("[TB] FAIL pre_reset_cycle %0d: got %h expected %h", k, dut_vec(), model_vec());
            else n_pass++;
        end
        pwm_update = 1'b0;
        n_checks++;
        if (active_ratio !== 8'd128)
            $display("[TB] FAIL pre_reset_active: got %0d expected 128", active_ratio);
        else n_pass++;
        reset = 1'b1;
        step();
        n_checks++;
        if (dut_vec() !== 13'd0)
            $display("[TB] FAIL reset_mid: got %h expected %h", dut_vec(), 13'd0);
        else n_pass++;
        reset = 1'b0; pwm_enable = 1'b0;
        step();
        test_first_update("after_reset");
    endtask

    initial begin
        reset = 1'b1; pwm_enable = 1'b0; pwm_update = 1'b0;
        pwm_ratio = 8'd0; pwm_direction = 1'b0;
        test_reset();
        test_first_update("first_update");
        test_ratio_change();
        test_reversal();
        test_hold_update();
        test_disable_in_dead();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
